// File: rtl/uart_param_core.sv
// uart_param_core: parameterised UART with a TX FIFO, 16x oversampled RX,
// optional even/odd parity and one or two TX stop bits.
module uart_param_core #(
   parameter int CLK_DIV    = 4,
   parameter int DATA_W     = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_W-1:0]           tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic [$clog2(FIFO_DEPTH):0] tx_level,
   output logic                        tx_busy,
   output logic                        txd,
   input  logic                        rxd,
   output logic [DATA_W-1:0]           rx_data,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   output logic                        rx_frame_err,
   output logic                        rx_parity_err,
   output logic                        rx_overrun
);
   localparam int   AW      = $clog2(FIFO_DEPTH);
   localparam int   LW      = AW + 1;
   localparam int   BIT_CYC = 16 * CLK_DIV;
   localparam int   TCW     = $clog2(BIT_CYC);
   localparam int   PCW     = $clog2(CLK_DIV);
   localparam logic PAR_ODD = (PARITY == 2);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

   // TX FIFO
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              push, pop, fifo_empty;
   logic [DATA_W-1:0] fifo_head;

   // TX engine
   tx_state_t         tx_state_q, tx_state_d;
   logic [TCW-1:0]    tx_cnt_q, tx_cnt_d;
   logic [3:0]        tx_idx_q, tx_idx_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic              tx_par_q, tx_par_d;
   logic              txd_q, txd_d, tx_busy_q, tx_busy_d;
   logic              tx_bit_end, tx_load;

   // RX engine
   logic              rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
   logic [PCW-1:0]    pre_q, pre_d;
   logic              os_tick;
   rx_state_t         rx_state_q, rx_state_d;
   logic [3:0]        rx_tick_q, rx_tick_d;
   logic [3:0]        rx_idx_q, rx_idx_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic              rx_par_q, rx_par_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              rx_ferr_q, rx_ferr_d, rx_perr_q, rx_perr_d;
   logic              rx_ovr_q, rx_ovr_d;
   logic              rx_sample, rx_done;

   assign fifo_empty = (level_q == '0);
   assign tx_ready   = (level_q != LW'(FIFO_DEPTH));
   assign push       = tx_valid && tx_ready;
   assign fifo_head  = fifo_mem[rd_ptr_q];
   assign tx_bit_end = (tx_cnt_q == TCW'(BIT_CYC - 1));
   assign os_tick    = (pre_q == PCW'(CLK_DIV - 1));
   assign rx_sample  = os_tick && (rx_tick_q == 4'd15);

   assign tx_level      = level_q;
   assign tx_busy       = tx_busy_q;
   assign txd           = txd_q;
   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_frame_err  = rx_ferr_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_overrun    = rx_ovr_q;

   // FIFO storage: write port only; the head word is captured into the TX shifter on pop
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= tx_data;
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
   end

   // TX frame sequencer; txd and tx_busy are registered from the next state so they never glitch
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + TCW'(1);
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_load    = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            if (!fifo_empty) tx_load = 1'b1;
         end
         TX_START: if (tx_bit_end) begin
            tx_cnt_d   = '0;
            tx_idx_d   = '0;
            tx_state_d = TX_DATA;
         end
         TX_DATA: if (tx_bit_end) begin
            tx_cnt_d   = '0;
            tx_shift_d = tx_shift_q >> 1;
            if (tx_idx_q == 4'(DATA_W - 1)) begin
               tx_idx_d   = '0;
               tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
            end else begin
               tx_idx_d = tx_idx_q + 4'd1;
            end
         end
         TX_PARITY: if (tx_bit_end) begin
            tx_cnt_d   = '0;
            tx_state_d = TX_STOP;
         end
         TX_STOP: if (tx_bit_end) begin
            tx_cnt_d = '0;
            if (tx_idx_q == 4'(STOP_BITS - 1)) begin
               tx_idx_d = '0;
               // chain straight into the next start bit when more data is waiting
               if (!fifo_empty) tx_load = 1'b1;
               else             tx_state_d = TX_IDLE;
            end else begin
               tx_idx_d = tx_idx_q + 4'd1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      if (tx_load) begin
         tx_state_d = TX_START;
         tx_cnt_d   = '0;
         tx_shift_d = fifo_head;
         tx_par_d   = (^fifo_head) ^ PAR_ODD;
      end
      pop = tx_load;
      case (tx_state_d)
         TX_START:  txd_d = 1'b0;
         TX_DATA:   txd_d = tx_shift_d[0];
         TX_PARITY: txd_d = tx_par_d;
         default:   txd_d = 1'b1;
      endcase
      tx_busy_d = (tx_state_d != TX_IDLE);
   end

   // RX synchronizer, oversample prescaler, frame sampler and output holding register
   always_comb begin
      rx_s1_d    = rxd;
      rx_s2_d    = rx_s1_q;
      pre_d      = os_tick ? '0 : pre_q + PCW'(1);
      rx_state_d = rx_state_q;
      rx_tick_d  = os_tick ? rx_tick_q + 4'd1 : rx_tick_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_par_d   = rx_par_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      rx_ferr_d  = rx_ferr_q;
      rx_perr_d  = rx_perr_q;
      rx_ovr_d   = 1'b0;
      rx_done    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_tick_d = '0;
            if (!rx_s2_q) rx_state_d = RX_START;
         end
         RX_START: if (os_tick && rx_tick_q == 4'd7) begin
            // mid start bit: a high line here means the low was only a glitch
            rx_tick_d  = '0;
            rx_idx_d   = '0;
            rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_sample) begin
            rx_shift_d = {rx_s2_q, rx_shift_q[DATA_W-1:1]};
            if (rx_idx_q == 4'(DATA_W - 1)) begin
               rx_idx_d   = '0;
               rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
            end else begin
               rx_idx_d = rx_idx_q + 4'd1;
            end
         end
         RX_PARITY: if (rx_sample) begin
            rx_par_d   = rx_s2_q;
            rx_state_d = RX_STOP;
         end
         RX_STOP: if (rx_sample) begin
            rx_done    = 1'b1;
            rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
      if (rx_done) begin
         if (!rx_valid_q || rx_ready) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_q;
            rx_ferr_d  = ~rx_s2_q;
            rx_perr_d  = (PARITY != 0) && (((^rx_shift_q) ^ rx_par_q) != PAR_ODD);
         end else begin
            rx_ovr_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         txd_q      <= 1'b1;
         tx_busy_q  <= 1'b0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         pre_q      <= '0;
         rx_state_q <= RX_IDLE;
         rx_tick_q  <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ovr_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         txd_q      <= txd_d;
         tx_busy_q  <= tx_busy_d;
         rx_s1_q    <= rx_s1_d;
         rx_s2_q    <= rx_s2_d;
         pre_q      <= pre_d;
         rx_state_q <= rx_state_d;
         rx_tick_q  <= rx_tick_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_par_q   <= rx_par_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_perr_q  <= rx_perr_d;
         rx_ovr_q   <= rx_ovr_d;
      end
   end
endmodule

// File: tb/tb_uart_param_core.sv
// tb_uart_param_core: self-checking bench for uart_param_core.
// u_a: defaults; u_b: odd parity, two stop bits; u_c: even parity (RX only).
module tb_uart_param_core;
   localparam int BIT = 64;   // 16 * CLK_DIV clocks per bit

   logic clk, rst;

   logic [7:0] tx_data_a, tx_data_b, tx_data_c;
   logic       tx_valid_a, tx_valid_b, tx_valid_c;
   logic       tx_ready_a, tx_ready_b, tx_ready_c;
   logic [3:0] tx_level_a, tx_level_b, tx_level_c;
   logic       tx_busy_a, tx_busy_b, tx_busy_c;
   logic       txd_a, txd_b, txd_c;
   logic       rxd_a, rxd_bc;
   logic [7:0] rx_data_a, rx_data_b, rx_data_c;
   logic       rx_valid_a, rx_valid_b, rx_valid_c;
   logic       rx_ready_a, rx_ready_bc;
   logic       rx_ferr_a, rx_ferr_b, rx_ferr_c;
   logic       rx_perr_a, rx_perr_b, rx_perr_c;
   logic       rx_ovr_a, rx_ovr_b, rx_ovr_c;

   int checks_cnt = 0;
   int errors_cnt = 0;
   int ovr_a_cnt  = 0;

   uart_param_core u_a (
      .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
      .tx_level(tx_level_a), .tx_busy(tx_busy_a), .txd(txd_a), .rxd(rxd_a), .rx_data(rx_data_a),
      .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_frame_err(rx_ferr_a),
      .rx_parity_err(rx_perr_a), .rx_overrun(rx_ovr_a));

   uart_param_core #(.PARITY(2), .STOP_BITS(2)) u_b (
      .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
      .tx_level(tx_level_b), .tx_busy(tx_busy_b), .txd(txd_b), .rxd(rxd_bc), .rx_data(rx_data_b),
      .rx_valid(rx_valid_b), .rx_ready(rx_ready_bc), .rx_frame_err(rx_ferr_b),
      .rx_parity_err(rx_perr_b), .rx_overrun(rx_ovr_b));

   uart_param_core #(.PARITY(1)) u_c (
      .clk(clk), .rst(rst), .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c),
      .tx_level(tx_level_c), .tx_busy(tx_busy_c), .txd(txd_c), .rxd(rxd_bc), .rx_data(rx_data_c),
      .rx_valid(rx_valid_c), .rx_ready(rx_ready_bc), .rx_frame_err(rx_ferr_c),
      .rx_parity_err(rx_perr_c), .rx_overrun(rx_ovr_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (rx_ovr_a === 1'b1) ovr_a_cnt++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic txd_of(input int inst);
      return (inst == 0) ? txd_a : txd_b;
   endfunction

   function automatic logic busy_of(input int inst);
      return (inst == 0) ? tx_busy_a : tx_busy_b;
   endfunction

   task automatic set_rxd(input int line, input logic v);
      if (line == 0) rxd_a = v;
      else           rxd_bc = v;
   endtask

   task automatic push(input int inst, input logic [7:0] d);
      if (inst == 0) begin tx_data_a = d; tx_valid_a = 1'b1; end
      else           begin tx_data_b = d; tx_valid_b = 1'b1; end
      @(negedge clk);
      tx_valid_a = 1'b0;
      tx_valid_b = 1'b0;
   endtask

   // Expected frame built from the data word; each bit checked at its first and last clock.
   task automatic tx_frame(input int inst, input logic [7:0] d, input bit immediate);
      logic bits [0:11];
      int   n, cyc, waited, par_mode, stops;
      par_mode = (inst == 0) ? 0 : 2;
      stops    = (inst == 0) ? 1 : 2;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = d[i];
      n = 9;
      if (par_mode == 1)      begin bits[n] = ^d;  n++; end
      else if (par_mode == 2) begin bits[n] = ~^d; n++; end
      for (int s = 0; s < stops; s++) begin bits[n] = 1'b1; n++; end
      if (immediate) begin
         @(negedge clk);
      end else begin
         waited = 0;
         do begin
            @(negedge clk);
            waited++;
         end while (txd_of(inst) !== 1'b0 && waited < 3000);
         if (txd_of(inst) !== 1'b0) begin
            check_eq("tx_start_seen", txd_of(inst), 0);
            return;
         end
      end
      check_eq("tx_busy_rise", busy_of(inst), 1);
      cyc = 0;
      for (int k = 0; k < n; k++) begin
         while (cyc < k*BIT) begin @(negedge clk); cyc++; end
         check_eq($sformatf("tx%0d_bit%0d_head", inst, k), txd_of(inst), bits[k]);
         while (cyc < k*BIT + BIT - 1) begin @(negedge clk); cyc++; end
         check_eq($sformatf("tx%0d_bit%0d_tail", inst, k), txd_of(inst), bits[k]);
      end
      check_eq("tx_busy_hold", busy_of(inst), 1);
      $display("tx frame inst=%0d data=%02h bits=%0d", inst, d, n);
   endtask

   task automatic tx_idle_check(input int inst);
      @(negedge clk);
      check_eq("tx_idle_txd", txd_of(inst), 1);
      check_eq("tx_idle_busy", busy_of(inst), 0);
   endtask

   // par < 0: no parity bit; bad stop is held low long enough to be sampled, then released
   task automatic rx_drive(input int line, input logic [7:0] d, input int par, input bit stop_ok);
      set_rxd(line, 1'b0); repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin set_rxd(line, d[i]); repeat (BIT) @(negedge clk); end
      if (par >= 0) begin set_rxd(line, par[0]); repeat (BIT) @(negedge clk); end
      if (stop_ok) begin
         set_rxd(line, 1'b1); repeat (BIT) @(negedge clk);
      end else begin
         set_rxd(line, 1'b0); repeat (48) @(negedge clk);
         set_rxd(line, 1'b1); repeat (16) @(negedge clk);
      end
      repeat (32) @(negedge clk);
   endtask

   task automatic rx_take(input string tag, input logic [7:0] d, input logic fe);
      check_eq({tag, "_valid"}, rx_valid_a, 1);
      check_eq({tag, "_data"}, rx_data_a, d);
      check_eq({tag, "_ferr"}, rx_ferr_a, fe);
      check_eq({tag, "_perr"}, rx_perr_a, 0);
      rx_ready_a = 1'b1;
      @(negedge clk);
      rx_ready_a = 1'b0;
      check_eq({tag, "_clear"}, rx_valid_a, 0);
      $display("rx frame %s data=%02h ferr=%0d", tag, d, fe);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] w [0:8];
      logic [7:0] d;
      bit         ok;
      int         ovr0, lows, valids, waited;

      rst = 1'b1;
      tx_data_a = '0; tx_data_b = '0; tx_data_c = '0;
      tx_valid_a = 1'b0; tx_valid_b = 1'b0; tx_valid_c = 1'b0;
      rxd_a = 1'b1; rxd_bc = 1'b1;
      rx_ready_a = 1'b0; rx_ready_bc = 1'b0;
      repeat (3) @(negedge clk);

      check_eq("rst_txd", txd_a, 1);
      check_eq("rst_busy", tx_busy_a, 0);
      check_eq("rst_ready", tx_ready_a, 1);
      check_eq("rst_level", tx_level_a, 0);
      check_eq("rst_rx_valid", rx_valid_a, 0);
      check_eq("rst_ferr", rx_ferr_a, 0);
      check_eq("rst_perr", rx_perr_a, 0);
      check_eq("rst_ovr", rx_ovr_a, 0);
      check_eq("rst_txd_b", txd_b, 1);
      rst = 1'b0;
      @(negedge clk);

      // single frame, default format
      push(0, 8'hA5);
      tx_frame(0, 8'hA5, 0);
      tx_idle_check(0);

      // odd parity with two stop bits, fixed word then a random one
      push(1, 8'h03);
      tx_frame(1, 8'h03, 0);
      tx_idle_check(1);
      d = 8'($urandom);
      push(1, d);
      tx_frame(1, d, 0);
      tx_idle_check(1);

      // burst of nine words, then a tenth against a full FIFO
      for (int i = 0; i < 9; i++) w[i] = 8'($urandom);
      fork
         begin
            for (int i = 0; i < 9; i++) begin
               tx_data_a = w[i]; tx_valid_a = 1'b1;
               @(negedge clk);
            end
            check_eq("fifo_level_full", tx_level_a, 8);
            check_eq("fifo_ready_full", tx_ready_a, 0);
            tx_data_a = 8'hEE; tx_valid_a = 1'b1;
            @(negedge clk);
            tx_valid_a = 1'b0;
            check_eq("fifo_full_ignore", tx_level_a, 8);
         end
         begin
            tx_frame(0, w[0], 0);
            for (int i = 1; i < 9; i++) tx_frame(0, w[i], 1);
         end
      join
      tx_idle_check(0);
      check_eq("fifo_drained", tx_level_a, 0);

      // overrun: second frame dropped while the first is unread
      ovr0 = ovr_a_cnt;
      rx_drive(0, 8'h5C, -1, 1);
      check_eq("ovr_first_valid", rx_valid_a, 1);
      check_eq("ovr_first_data", rx_data_a, 8'h5C);
      rx_drive(0, 8'h12, -1, 1);
      check_eq("ovr_pulses", ovr_a_cnt - ovr0, 1);
      rx_take("ovr_kept", 8'h5C, 0);

      // random frames, some with a low stop bit
      for (int i = 0; i < 6; i++) begin
         d  = 8'($urandom);
         ok = ($urandom_range(0, 3) != 0);
         ovr0 = ovr_a_cnt;
         rx_drive(0, d, -1, ok);
         check_eq("rx_rand_no_ovr", ovr_a_cnt - ovr0, 0);
         rx_take("rx_rand", d, ~ok);
      end

      // short glitch must not start a frame
      rxd_a = 1'b0;
      repeat (12) @(negedge clk);
      rxd_a = 1'b1;
      repeat (700) @(negedge clk);
      check_eq("rx_glitch_reject", rx_valid_a, 0);

      rx_drive(0, 8'h3C, -1, 0);
      rx_take("rx_ferr", 8'h3C, 1);

      // parity: the same line feeds an odd (u_b) and an even (u_c) receiver
      for (int p = 0; p < 2; p++) begin
         d = 8'($urandom);
         rx_drive(1, d, (p == 0) ? int'(^d) : int'(~^d), 1);
         check_eq("par_b_valid", rx_valid_b, 1);
         check_eq("par_c_valid", rx_valid_c, 1);
         check_eq("par_b_data", rx_data_b, d);
         check_eq("par_c_data", rx_data_c, d);
         check_eq("par_b_err", rx_perr_b, (p == 0) ? 1 : 0);
         check_eq("par_c_err", rx_perr_c, (p == 0) ? 0 : 1);
         check_eq("par_b_ferr", rx_ferr_b, 0);
         rx_ready_bc = 1'b1;
         @(negedge clk);
         rx_ready_bc = 1'b0;
         check_eq("par_b_clear", rx_valid_b, 0);
         check_eq("par_c_clear", rx_valid_c, 0);
         $display("rx parity frame data=%02h pbit=%0d", d, (p == 0) ? ^d : ~^d);
      end

      // reset in the middle of TX data bit 3 and RX data bits
      for (int i = 0; i < 3; i++) begin
         tx_data_a = 8'($urandom); tx_valid_a = 1'b1;
         @(negedge clk);
      end
      tx_valid_a = 1'b0;
      waited = 0;
      while (txd_a !== 1'b0 && waited < 3000) begin @(negedge clk); waited++; end
      check_eq("rst_test_start", txd_a, 0);
      d = 8'($urandom);
      for (int c = 0; c < 4*BIT + 24; c++) begin
         rxd_a = (c < BIT) ? 1'b0 : d[c/BIT - 1];
         @(negedge clk);
      end
      check_eq("rst_test_level", tx_level_a, 2);
      rst = 1'b1;
      rxd_a = 1'b1;
      @(negedge clk);
      check_eq("midrst_txd", txd_a, 1);
      check_eq("midrst_level", tx_level_a, 0);
      check_eq("midrst_busy", tx_busy_a, 0);
      check_eq("midrst_ready", tx_ready_a, 1);
      check_eq("midrst_rx_valid", rx_valid_a, 0);
      rst = 1'b0;
      lows = 0; valids = 0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         if (txd_a !== 1'b1) lows++;
         if (rx_valid_a !== 1'b0) valids++;
      end
      check_eq("midrst_tx_quiet", lows, 0);
      check_eq("midrst_rx_quiet", valids, 0);
      $display("reset transaction rx_word=%02h abandoned", d);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end
endmodule

// File: doc/uart_param_core.md
UART_PARAM_CORE -- requirements
Module: uart_param_core

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 4: clk cycles per oversample tick; one bit period is 16*CLK_DIV clk cycles; legal values are 2 or more.
REQ-002 The module SHALL have parameter DATA_W, default 8: data bits per frame; legal values are 5 to 9.
REQ-003 The module SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 The module SHALL have parameter STOP_BITS, default 1: TX stop bits; legal values are 1 and 2.
REQ-005 The module SHALL have parameter FIFO_DEPTH, default 8: TX FIFO entries; must be a power of 2, minimum 2.
REQ-006 Port clk  input  1  sole clock; all logic is on its rising edge.
REQ-007 Port rst  input  1  synchronous reset, active-high.
REQ-008 Port tx_data  input  DATA_W  byte to enqueue.
REQ-009 Port tx_valid  input  1  enqueue request.
REQ-010 Port tx_ready  output  1  high when the TX FIFO is not full.
REQ-011 Port tx_level  output  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy.
REQ-012 Port tx_busy  output  1  high while a frame is on txd.
REQ-013 Port txd  output  1  serial out; idle high.
REQ-014 Port rxd  input  1  asynchronous serial in.
REQ-015 Port rx_data  output  DATA_W  received word.
REQ-016 Port rx_valid  output  1  rx_data is valid.
REQ-017 Port rx_ready  input  1  consumer accepts rx_data.
REQ-018 Port rx_frame_err  output  1  first stop bit was sampled low; valid with rx_valid.
REQ-019 Port rx_parity_err  output  1  parity mismatch; valid with rx_valid; held 0 when PARITY=0.
REQ-020 Port rx_overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-021 Enqueue SHALL occur on a cycle with tx_valid && tx_ready; the write pointer SHALL wrap modulo FIFO_DEPTH.
REQ-022 When full, tx_ready SHALL be 0 and tx_valid SHALL be ignored, with no data corruption.
REQ-023 A push and a pop in the same cycle SHALL leave tx_level unchanged.
REQ-024 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP, in that order.
- PARITY is skipped when PARITY=0.
- STOP lasts STOP_BITS bit periods.
- STOP then returns to IDLE.
REQ-025 In IDLE with the FIFO non-empty, the TX SHALL pop one word; txd SHALL go low on the next cycle, and tx_busy SHALL rise with it.
REQ-026 Each TX bit SHALL be held exactly 16*CLK_DIV cycles, timed by a dedicated TX counter that restarts at each pop.
REQ-027 Data SHALL be sent LSB first.
- Even parity bit = XOR of the data bits.
- Odd parity bit = the inverse of that XOR.
REQ-028 Back-to-back frames SHALL have no idle gap when the FIFO is non-empty at the end of STOP; tx_busy SHALL stay high across them.
REQ-029 rxd SHALL pass through a 2-flop synchronizer.
REQ-030 A free-running prescaler SHALL generate a one-cycle os_tick every CLK_DIV cycles.
REQ-031 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- IDLE: on a synchronized low, go to START and reset the tick count.
- START: after 8 os_ticks resample; if high, it is a false start and the FSM returns to IDLE; if low, go to DATA.
- DATA/PARITY/STOP: each bit is sampled 16 os_ticks after the previous sample.
REQ-032 At the first stop-bit sample, the RX SHALL load rx_data, rx_frame_err and rx_parity_err, set rx_valid, and return to IDLE; it is ready for a new start bit immediately.
REQ-033 rx_valid SHALL clear on the cycle after rx_valid && rx_ready.
REQ-034 If a frame completes while rx_valid=1 and rx_ready=0:
- the new frame is dropped;
- the old data and flags are kept;
- rx_overrun pulses for 1 cycle.
REQ-035 If a frame completes on the same cycle as an rx_valid && rx_ready handshake, the new frame SHALL be loaded, rx_valid SHALL stay 1, and there is no overrun.
REQ-036 For DATA_W<9, the unused upper bits of rx_data SHALL not exist; no padding is added.

Reset
REQ-037 On rst=1 at a clk edge, outputs SHALL take these values on the next edge:
- txd=1, tx_busy=0, tx_ready=1, tx_level=0;
- rx_valid=0, all error flags 0, rx_overrun=0.
REQ-038 Reset SHALL flush the FIFO, set both FSMs to IDLE, clear all counters, and set the synchronizer flops to 1.
REQ-039 Reset mid-frame SHALL abandon the frame with no partial delivery; txd SHALL be 1 on the cycle after reset asserts.

Verification
REQ-040 Defaults, push 8'hA5, pulse low -> txd low for 64 cycles, then bits 1,0,1,0,0,1,0,1 at 64 cycles each, then high for 64 cycles; tx_busy is high for 640 cycles.
REQ-041 PARITY=2, STOP_BITS=2, push 8'h03 -> parity bit 1, two stop periods, frame length 12*64 cycles.
REQ-042 Push 9 words back-to-back -> 8 are accepted while the first has already popped; tx_ready drops when tx_level=8; all 9 are transmitted in order with no idle gaps.
REQ-043 Drive the 8'h5C frame on rxd with rx_ready=0, then drive 8'h12 -> rx_data=8'h5C is kept and rx_overrun pulses once; asserting rx_ready clears rx_valid.
REQ-044 Drive a 3-oversample low glitch, then a stop bit at 0 on a full frame -> the glitch is rejected with no rx_valid; the frame delivers with rx_frame_err=1; a PARITY=1 wrong-parity frame gives rx_parity_err=1.
REQ-045 Assert rst during the DATA bit 3 transmit and during RX DATA -> txd=1 on the next cycle, tx_level=0, and no rx_valid follows.
